pool_window_feeder: RTL and testbench

- Upstream feeder for the 2x2 average-pooling stage.
- Accepts a feature map as a raster-order pixel stream (valid/ready) and buffers one row. It then forms non-overlapping 2x2 stride-2 windows.
- For each window it drives the pooler's start/finish handshake, captures the pooled pixel, and emits it on an output stream with an end-of-frame marker.
- Sits between the convolution output stream and the pooling stage.

---
 rtl/pool_window_feeder.sv | 159 +++++++++++++++
 tb/tb_pool_window_feeder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// pool_window_feeder
//   Sits between the convolution output stream and the 2x2 average pooler.
//   Buffers one even row of the raster-order input, forms non-overlapping
//   2x2 stride-2 windows, runs the pooler start/finish handshake for each
//   window and forwards the pooled pixel downstream with an end-of-frame flag.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input pixel stream handshake
//   in_pixel                 input pixel, raster order, signed
//   win_start                pooler start, level, held until pool_finish
//   win_p00..win_p11         window pixels [row][col] presented to the pooler
//   pool_finish, pool_pixel  pooler completion flag and result
//   out_valid/out_ready      output stream handshake
//   out_pixel, out_last      pooled pixel, final-window-of-frame marker
module pool_window_feeder #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              win_start,
    output logic [DATA_W-1:0] win_p00,
    output logic [DATA_W-1:0] win_p01,
    output logic [DATA_W-1:0] win_p10,
    output logic [DATA_W-1:0] win_p11,
    input  logic              pool_finish,
    input  logic [DATA_W-1:0] pool_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [RW-1:0] ONE_R   = RW'(1);
    // Last odd row/column: an odd trailing row/column never completes a window.
    localparam logic [CW-1:0] LAST_WIN_COL = CW'((IMG_W / 2) * 2 - 1);
    localparam logic [RW-1:0] LAST_WIN_ROW = RW'((IMG_H / 2) * 2 - 1);

    typedef enum logic [1:0] {FILL, ISSUE, DRAIN} state_t;

    state_t            state_reg;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;
    logic [DATA_W-1:0] left_reg;
    logic [DATA_W-1:0] lb [IMG_W];
    logic [DATA_W-1:0] win_p00_reg, win_p01_reg, win_p10_reg, win_p11_reg;
    logic              win_start_reg;
    logic              win_last_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_pixel_reg;
    logic              out_last_reg;
    logic              out_taken_reg;

    logic accept;
    logic win_done;

    // in_ready is forced low while reset is asserted, not just after it.
    assign in_ready = (state_reg == FILL) && !rst;
    assign accept   = in_valid && in_ready;
    // Odd row and odd column means the bottom-right pixel of a window.
    assign win_done = accept && row_reg[0] && col_reg[0];

    assign win_start = win_start_reg;
    assign win_p00   = win_p00_reg;
    assign win_p01   = win_p01_reg;
    assign win_p10   = win_p10_reg;
    assign win_p11   = win_p11_reg;
    assign out_valid = out_valid_reg;
    assign out_pixel = out_pixel_reg;
    assign out_last  = out_last_reg;

    // Line buffer holds the even row; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept && !row_reg[0]) begin
            lb[col_reg] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILL;
            col_reg       <= '0;
            row_reg       <= '0;
            left_reg      <= '0;
            win_p00_reg   <= '0;
            win_p01_reg   <= '0;
            win_p10_reg   <= '0;
            win_p11_reg   <= '0;
            win_start_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
            out_last_reg  <= 1'b0;
            out_taken_reg <= 1'b0;
        end else begin
            if (accept) begin
                left_reg <= in_pixel;
                if (col_reg == COL_MAX) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + ONE_R;
                end else begin
                    col_reg <= col_reg + ONE_C;
                end
            end

            case (state_reg)
                FILL: begin
                    if (win_done) begin
                        win_p00_reg   <= lb[col_reg - ONE_C];
                        win_p01_reg   <= lb[col_reg];
                        win_p10_reg   <= left_reg;
                        win_p11_reg   <= in_pixel;
                        win_last_reg  <= (row_reg == LAST_WIN_ROW) &&
                                         (col_reg == LAST_WIN_COL);
                        win_start_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (pool_finish) begin
                        out_pixel_reg <= pool_pixel;
                        out_last_reg  <= win_last_reg;
                        out_valid_reg <= 1'b1;
                        out_taken_reg <= 1'b0;
                        win_start_reg <= 1'b0;
                        state_reg     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Output may be taken while the pooler still holds finish;
                    // remember that and wait for finish to drop before the
                    // next window so the pooler sees a fresh start.
                    if (out_ready && out_valid_reg) begin
                        out_valid_reg <= 1'b0;
                        out_taken_reg <= 1'b1;
                    end
                    if ((out_ready || out_taken_reg) && !pool_finish) begin
                        out_valid_reg <= 1'b0;
                        out_taken_reg <= 1'b0;
                        state_reg     <= FILL;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
module tb_pool_window_feeder;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          sel = 1'b0;          // 0: 4x4 instance, 1: 5x3 instance
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          out_ready = 1'b1;
    logic          pool_finish = 1'b0;
    logic [DW-1:0] pool_pixel = '0;

    logic          a_in_ready, a_win_start, a_out_valid, a_out_last;
    logic [DW-1:0] a_p00, a_p01, a_p10, a_p11, a_out_pixel;
    logic          b_in_ready, b_win_start, b_out_valid, b_out_last;
    logic [DW-1:0] b_p00, b_p01, b_p10, b_p11, b_out_pixel;

    logic          in_ready, win_start, out_valid, out_last;
    logic [DW-1:0] win_p00, win_p01, win_p10, win_p11, out_pixel;

    pool_window_feeder #(.IMG_W(4), .IMG_H(4), .DATA_W(DW)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_pixel(in_pixel),
        .win_start(a_win_start),
        .win_p00(a_p00), .win_p01(a_p01), .win_p10(a_p10), .win_p11(a_p11),
        .pool_finish(pool_finish && !sel), .pool_pixel(pool_pixel),
        .out_valid(a_out_valid), .out_ready(out_ready && !sel),
        .out_pixel(a_out_pixel), .out_last(a_out_last)
    );

    pool_window_feeder #(.IMG_W(5), .IMG_H(3), .DATA_W(DW)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_pixel(in_pixel),
        .win_start(b_win_start),
        .win_p00(b_p00), .win_p01(b_p01), .win_p10(b_p10), .win_p11(b_p11),
        .pool_finish(pool_finish && sel), .pool_pixel(pool_pixel),
        .out_valid(b_out_valid), .out_ready(out_ready && sel),
        .out_pixel(b_out_pixel), .out_last(b_out_last)
    );

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign win_start = sel ? b_win_start : a_win_start;
    assign win_p00   = sel ? b_p00 : a_p00;
    assign win_p01   = sel ? b_p01 : a_p01;
    assign win_p10   = sel ? b_p10 : a_p10;
    assign win_p11   = sel ? b_p11 : a_p11;
    assign out_valid = sel ? b_out_valid : a_out_valid;
    assign out_pixel = sel ? b_out_pixel : a_out_pixel;
    assign out_last  = sel ? b_out_last  : a_out_last;

    typedef struct packed {
        logic [DW-1:0] p00, p01, p10, p11;
    } win_t;
    typedef struct packed {
        logic [DW-1:0] pix;
        logic          last;
    } res_t;

    win_t wq[$];
    res_t rq[$];

    int vectors = 0;
    int miscompares = 0;
    int nout = 0;
    int hold_extra = 0;
    int hold_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor first, then behavioural pooler, in one block so the sampled
    // finish level is exactly what the DUT sees at the next rising edge.
    logic prev_start = 1'b0;
    logic prev_fin   = 1'b0;
    win_t w_exp;
    res_t r_exp;
    int   psum;
    always @(negedge clk) begin
        if (rst) begin
            prev_start  = 1'b0;
            prev_fin    = 1'b0;
            pool_finish = 1'b0;
            hold_cnt    = 0;
        end else begin
            if (win_start && !prev_start) begin
                check("start_while_finish", {31'd0, prev_fin}, 32'd0);
                if (wq.size() == 0) begin
                    check("unexpected_window", 32'd1, 32'd0);
                end else begin
                    w_exp = wq.pop_front();
                    check("win_p00", {16'd0, win_p00}, {16'd0, w_exp.p00});
                    check("win_p01", {16'd0, win_p01}, {16'd0, w_exp.p01});
                    check("win_p10", {16'd0, win_p10}, {16'd0, w_exp.p10});
                    check("win_p11", {16'd0, win_p11}, {16'd0, w_exp.p11});
                end
            end
            prev_start = win_start;
            if (win_start || out_valid) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (rq.size() == 0) begin
                    check("extra_output", 32'd1, 32'd0);
                end else begin
                    r_exp = rq.pop_front();
                    check("out_pixel", {16'd0, out_pixel}, {16'd0, r_exp.pix});
                    check("out_last", {31'd0, out_last}, {31'd0, r_exp.last});
                    $display("out pixel=%0d last=%0b", $signed(out_pixel), out_last);
                    nout++;
                end
            end
            // pooler: finish one cycle after start, held until start drops
            // plus hold_extra cycles
            if (pool_finish) begin
                if (!win_start) begin
                    if (hold_cnt == 0) pool_finish = 1'b0;
                    else hold_cnt--;
                end
            end else if (win_start) begin
                psum = int'($signed(win_p00)) + int'($signed(win_p01)) +
                       int'($signed(win_p10)) + int'($signed(win_p11));
                pool_pixel  = DW'(psum / 4);
                pool_finish = 1'b1;
                hold_cnt    = hold_extra;
            end
            prev_fin = pool_finish;
        end
    end

    task automatic send_pixel(input logic [DW-1:0] val, output bit ok);
        int t;
        ok = 1'b0;
        t = 0;
        in_valid = 1'b1;
        in_pixel = val;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // mode 0: ramp 0..w*h-1; mode 1: ramp with the first window set to -8
    task automatic send_frame(input int w, input int h, input int mode);
        int   pix[0:63];
        int   acc, r, c, lr, lc, s, t;
        bit   ok;
        win_t wn;
        res_t rs;
        for (int i = 0; i < w * h; i++) pix[i] = i;
        if (mode == 1) begin
            pix[0] = -8; pix[1] = -8; pix[w] = -8; pix[w + 1] = -8;
        end
        lr = (h % 2 == 0) ? h - 1 : h - 2;
        lc = (w % 2 == 0) ? w - 1 : w - 2;
        acc = 0;
        for (int i = 0; i < w * h; i++) begin
            r = i / w;
            c = i % w;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                wn.p00 = DW'(pix[(r - 1) * w + c - 1]);
                wn.p01 = DW'(pix[(r - 1) * w + c]);
                wn.p10 = DW'(pix[r * w + c - 1]);
                wn.p11 = DW'(pix[r * w + c]);
                s = pix[(r - 1) * w + c - 1] + pix[(r - 1) * w + c] +
                    pix[r * w + c - 1] + pix[r * w + c];
                rs.pix  = DW'(s / 4);
                rs.last = (r == lr) && (c == lc);
                wq.push_back(wn);
                rq.push_back(rs);
            end
            send_pixel(DW'(pix[i]), ok);
            if (ok) acc++;
        end
        in_valid = 1'b0;
        check("pixels_accepted", acc, w * h);
        t = 0;
        while ((rq.size() != 0 || win_start || out_valid) && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("results_pending", rq.size(), 32'd0);
        check("windows_pending", wq.size(), 32'd0);
    endtask

    task automatic stall_ctl();
        int t;
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_pixel", {16'd0, out_pixel}, 32'd2);
            check("stall_win_start", {31'd0, win_start}, 32'd0);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        int  n0;
        bit  ok;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_win_start", {31'd0, win_start}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pixel", {16'd0, out_pixel}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_win_p00", {16'd0, win_p00}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // two back-to-back 4x4 ramp frames
        send_frame(4, 4, 0);
        send_frame(4, 4, 0);
        // negative first window
        send_frame(4, 4, 1);

        // downstream stall on the first result
        out_ready = 1'b0;
        fork
            send_frame(4, 4, 0);
            stall_ctl();
        join

        // pooler holds finish after start drops
        hold_extra = 3;
        n0 = nout;
        send_frame(4, 4, 0);
        check("hold_output_count", nout - n0, 32'd4);
        hold_extra = 0;

        // reset while a window is being issued
        for (int i = 0; i < 6; i++) send_pixel(DW'(i), ok);
        in_valid = 1'b0;
        check("pre_rst_win_start", {31'd0, win_start}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_win_start", {31'd0, win_start}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(4, 4, 0);

        // odd geometry: 5x3, twice to confirm the frame restarts cleanly
        sel = 1'b1;
        #1;
        send_frame(5, 3, 0);
        send_frame(5, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
